// File: rtl/note_sequencer.sv
// note_sequencer: walks a note ROM and feeds freqGenerator a timed threshold/enable per note, with a silent gap between notes
module note_sequencer #(
    parameter int CLK_HZ = 48_000_000,
    parameter int ADDR_W = 8,
    parameter int GAP_MS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [47:0]       rom_data,
    output logic [31:0]       threshold,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PRE_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int GAP_CYC = GAP_MS * TICK_DIV;
    localparam int GAP_W = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, FINISH} state_t;
    state_t state, state_n;
    logic play_q, last;
    logic [PRE_W-1:0] pre;
    logic [15:0] dur;
    logic [GAP_W-1:0] gcnt;
    logic tick, note_end, gap_end, is_end, stop;
    assign tick = pre == PRE_W'(TICK_DIV - 1);
    assign note_end = tick && dur == 16'd1;
    assign gap_end = gcnt == GAP_W'(GAP_CYC - 1);
    assign is_end = rom_data[15:0] == 16'd0;
    // entering FINISH without loop ends the song; done is registered so FINISH reads it back
    assign stop = state_n == FINISH && !loop;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = play && !play_q ? FETCH : IDLE;
            FETCH:   state_n = LOAD;
            LOAD:    state_n = is_end ? FINISH : PLAY;
            PLAY:    state_n = !note_end ? PLAY : GAP_MS != 0 ? GAP : &rom_addr ? FINISH : FETCH;
            GAP:     state_n = !gap_end ? GAP : last ? FINISH : FETCH;
            FINISH:  state_n = done ? IDLE : FETCH;
            default: state_n = IDLE;
        endcase
        if (!play) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            play_q    <= 1'b0;
            rom_addr  <= '0;
            threshold <= '0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pre       <= '0;
            dur       <= '0;
            gcnt      <= '0;
            last      <= 1'b0;
        end else begin
            state     <= state_n;
            play_q    <= play;
            busy      <= state_n != IDLE && !stop;
            done      <= stop;
            tone_en   <= state_n == PLAY && (state == LOAD ? rom_data[47:16] != 32'd0 : threshold != 32'd0);
            threshold <= state_n == IDLE ? '0 : state == LOAD && !is_end ? rom_data[47:16] : threshold;
            rom_addr  <= state_n == IDLE || state_n == FINISH ? '0 : state == PLAY && note_end ? rom_addr + 1'b1 : rom_addr;
            pre       <= state != PLAY || tick ? '0 : pre + 1'b1;
            dur       <= state == LOAD ? rom_data[15:0] : state == PLAY && tick ? dur - 16'd1 : dur;
            gcnt      <= state == GAP ? gcnt + 1'b1 : '0;
            // the last ROM slot finishing acts as an implicit end marker once the address wraps
            last      <= state == PLAY && note_end ? &rom_addr : last;
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scenario table plus abort/reset sequences, checked cycle by cycle against a queued expected trace
module tb_note_sequencer;
    logic clk = 1'b0, reset, play, loop;
    logic [1:0] rom_addr;
    logic [47:0] rom_data;
    logic [31:0] threshold;
    logic tone_en, busy, done;
    logic [3:0][47:0] rom;
    int compared = 0, mism = 0;
    int nd, nt;
    typedef struct packed {
        logic tone;
        logic bsy;
        logic dn;
        logic [1:0] addr;
        logic [31:0] thr;
    } exp_t;
    typedef struct {
        logic [3:0][47:0] rom;
        logic lp;
        int cycles;
        int exp_done;
        int exp_tone;
        string name;
    } vec_t;
    exp_t q[$];
    vec_t vt[4];
    note_sequencer #(.CLK_HZ(4000), .ADDR_W(2), .GAP_MS(1)) dut (
        .clk(clk), .reset(reset), .play(play), .loop(loop), .rom_addr(rom_addr),
        .rom_data(rom_data), .threshold(threshold), .tone_en(tone_en), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];
    function automatic logic [47:0] nw(input int th, input int d);
        return {th[31:0], d[15:0]};
    endfunction
    task automatic push(input logic t, input logic b, input logic d, input int a, input logic [31:0] th);
        exp_t e;
        e.tone = t; e.bsy = b; e.dn = d; e.addr = 2'(a); e.thr = th;
        q.push_back(e);
    endtask
    // expected per-cycle trace from play's sampling edge: FETCH, LOAD, dur*4 tone, 4 gap, ...
    task automatic build(input logic lp, input int n);
        int addr, d;
        logic [31:0] th, cur;
        logic fin;
        addr = 0; cur = 0;
        q.delete();
        while (q.size() < n) begin
            fin = 1'b0;
            push(0, 1, 0, addr, cur);
            push(0, 1, 0, addr, cur);
            d = int'(rom[addr][15:0]);
            th = rom[addr][47:16];
            if (d == 0) fin = 1'b1;
            else begin
                cur = th;
                for (int i = 0; i < d * 4; i++) push(th != 0, 1, 0, addr, cur);
                for (int i = 0; i < 4; i++) push(0, 1, 0, (addr + 1) % 4, cur);
                fin = addr == 3;
                addr = (addr + 1) % 4;
            end
            if (fin) begin
                push(0, lp, !lp, 0, cur);
                addr = 0;
                if (!lp) while (q.size() < n) push(0, 0, 0, 0, 0);
            end
        end
    endtask
    task automatic run(input string nm, input int n, output int ndone, output int ntone);
        exp_t e, g;
        ndone = 0; ntone = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = q.pop_front();
            g = {tone_en, busy, done, rom_addr, threshold};
            compared++;
            if (g !== e) begin
                mism++;
                $display("FAIL %s cyc %0d: got tone=%b busy=%b done=%b addr=%0d thr=%0d, want tone=%b busy=%b done=%b addr=%0d thr=%0d",
                         nm, i, g.tone, g.bsy, g.dn, g.addr, g.thr, e.tone, e.bsy, e.dn, e.addr, e.thr);
            end
            ndone += int'(done);
            ntone += int'(tone_en);
        end
    endtask
    task automatic check(input string nm, input longint got, input longint want);
        compared++;
        if (got != want) begin
            mism++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        vt[0] = '{rom: {nw(1, 1), nw(1, 1), nw(12345, 0), nw(27272, 3)}, lp: 1'b0, cycles: 26, exp_done: 1, exp_tone: 12, name: "single"};
        vt[1] = '{rom: {nw(1, 1), nw(0, 0), nw(13636, 1), nw(0, 2)}, lp: 1'b0, cycles: 32, exp_done: 1, exp_tone: 4, name: "rest"};
        vt[2] = '{rom: {nw(1, 1), nw(0, 0), nw(13636, 1), nw(0, 2)}, lp: 1'b1, cycles: 80, exp_done: 0, exp_tone: 12, name: "loop"};
        vt[3] = '{rom: {nw(100, 1), nw(100, 1), nw(100, 1), nw(100, 1)}, lp: 1'b0, cycles: 46, exp_done: 1, exp_tone: 16, name: "wrap"};
        reset = 1'b1; play = 1'b0; loop = 1'b0; rom = '0;
        @(negedge clk);
        check("reset_state", {tone_en, busy, done, rom_addr, threshold}, 0);
        reset = 1'b0;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            rom = vt[v].rom; loop = vt[v].lp; play = 1'b1;
            build(vt[v].lp, vt[v].cycles);
            run(vt[v].name, vt[v].cycles, nd, nt);
            check({vt[v].name, "_done_cnt"}, nd, vt[v].exp_done);
            check({vt[v].name, "_tone_cnt"}, nt, vt[v].exp_tone);
            play = 1'b0;
            @(negedge clk);
            check({vt[v].name, "_idle"}, {tone_en, busy, done, rom_addr, threshold}, 0);
            loop = 1'b0;
        end
        // abort five cycles into a note, then restart from address 0
        @(negedge clk);
        rom = vt[0].rom; play = 1'b1;
        build(1'b0, 7);
        run("abort_pre", 7, nd, nt);
        play = 1'b0;
        @(negedge clk);
        check("abort_outputs", {tone_en, busy, done, rom_addr, threshold}, 0);
        @(negedge clk);
        play = 1'b1;
        build(1'b0, 26);
        run("restart", 26, nd, nt);
        check("restart_done_cnt", nd, 1);
        check("restart_tone_cnt", nt, 12);
        play = 1'b0;
        @(negedge clk);
        // asynchronous reset between edges during the second note
        @(negedge clk);
        rom = vt[1].rom; play = 1'b1;
        build(1'b0, 18);
        run("pre_reset", 18, nd, nt);
        @(posedge clk);
        #2 reset = 1'b1; play = 1'b0;
        #1 check("reset_async", {tone_en, busy, done, rom_addr, threshold}, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_idle", {tone_en, busy, done, rom_addr, threshold}, 0);
        end
        play = 1'b1;
        build(1'b0, 32);
        run("post_reset_run", 32, nd, nt);
        check("post_reset_done_cnt", nd, 1);
        check("post_reset_tone_cnt", nt, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
